// File: rtl/rtc_cfg_seq.sv
// RTC configuration sequencer: runs the protected-write protocol (poll LWOFF, enter CMF,
// write PSCR/CNT/ALRM as selected, leave CMF, poll LWOFF) as the sole RTC bus master.
//
//   state      | meaning
//   IDLE       | ready for a request
//   RD_CTRL    | read CTRL into the shadow
//   POLL1      | poll SSTA until LWOFF before entering CMF
//   WR_ENTER   | write CTRL with CMF set
//   WR_PSCR    | write prescaler (mask bit0)
//   WR_CNT     | write counter (mask bit1)
//   WR_ALRM    | write alarm (mask bit2)
//   WR_EXIT    | write CTRL with CMF cleared
//   POLL2      | poll SSTA until LWOFF after leaving CMF
//   DONE       | one-cycle done pulse with status
module rtc_cfg_seq #(
    parameter int POLL_MAX = 1024,
    parameter int PSCR_MIN = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_req_i,
    output logic        cfg_rdy_o,
    input  logic [2:0]  cfg_mask_i,
    input  logic [19:0] cfg_pscr_i,
    input  logic [31:0] cfg_cnt_i,
    input  logic [31:0] cfg_alrm_i,
    output logic        cfg_done_o,
    output logic [1:0]  cfg_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rdy_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int            CW        = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_MAX);
    localparam logic [19:0]   PSCR_LO   = 20'(PSCR_MIN);

    localparam logic [31:0] A_CTRL = 32'h0000_0000;
    localparam logic [31:0] A_PSCR = 32'h0000_0004;
    localparam logic [31:0] A_CNT  = 32'h0000_0008;
    localparam logic [31:0] A_ALRM = 32'h0000_000C;
    localparam logic [31:0] A_SSTA = 32'h0000_0014;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
    localparam logic [1:0] ERR_PSCR = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CTRL,
        S_POLL1,
        S_WR_ENTER,
        S_WR_PSCR,
        S_WR_CNT,
        S_WR_ALRM,
        S_WR_EXIT,
        S_POLL2,
        S_DONE
    } state_t;

    state_t        state_q, state_n;
    logic [2:0]    mask_q, mask_n;
    logic [19:0]   pscr_q, pscr_n;
    logic [31:0]   cnt_q, cnt_n;
    logic [31:0]   alrm_q, alrm_n;
    logic [4:0]    shadow_q, shadow_n;
    logic [CW-1:0] poll_q, poll_n;
    logic [CW-1:0] poll_inc;
    logic [1:0]    err_q, err_n;
    logic          req_q, req_n;
    logic          we_q, we_n;
    logic [31:0]   addr_q, addr_n;
    logic [31:0]   wdata_q, wdata_n;

    logic          hs;
    logic          bus_state;
    logic          st_we;
    logic [31:0]   st_addr;
    logic [31:0]   st_wdata;

    // Only SSTA.LWOFF and the low CTRL bits matter to the sequencer.
    logic unused_rdata;
    assign unused_rdata = ^bus_rdata_i[31:5];

    assign hs       = req_q & bus_rdy_i;
    assign poll_inc = poll_q + CW'(1);

    // First selected write at or after the given pending bits, else the CMF exit write.
    function automatic state_t next_write(input logic [2:0] pending);
        if (pending[0])      return S_WR_PSCR;
        else if (pending[1]) return S_WR_CNT;
        else if (pending[2]) return S_WR_ALRM;
        else                 return S_WR_EXIT;
    endfunction

    always_comb begin
        bus_state = 1'b1;
        st_we     = 1'b1;
        st_addr   = A_CTRL;
        st_wdata  = 32'h0;
        case (state_q)
            S_RD_CTRL: begin
                st_we   = 1'b0;
                st_addr = A_CTRL;
            end
            S_POLL1, S_POLL2: begin
                st_we   = 1'b0;
                st_addr = A_SSTA;
            end
            S_WR_ENTER: st_wdata = {27'b0, shadow_q | 5'b00001};
            S_WR_PSCR: begin
                st_addr  = A_PSCR;
                st_wdata = {12'b0, pscr_q};
            end
            S_WR_CNT: begin
                st_addr  = A_CNT;
                st_wdata = cnt_q;
            end
            S_WR_ALRM: begin
                st_addr  = A_ALRM;
                st_wdata = alrm_q;
            end
            S_WR_EXIT: st_wdata = {27'b0, shadow_q & 5'b11110};
            default: begin
                bus_state = 1'b0;
                st_we     = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_n  = state_q;
        mask_n   = mask_q;
        pscr_n   = pscr_q;
        cnt_n    = cnt_q;
        alrm_n   = alrm_q;
        shadow_n = shadow_q;
        poll_n   = poll_q;
        err_n    = err_q;
        req_n    = req_q;
        we_n     = we_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;

        // The entry cycle of every bus state (and the cycle after each handshake)
        // leaves req low, which gives the mandatory idle gap between transfers.
        if (bus_state && !req_q) begin
            req_n   = 1'b1;
            we_n    = st_we;
            addr_n  = st_addr;
            wdata_n = st_wdata;
        end
        if (hs) begin
            req_n = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_req_i) begin
                    mask_n = cfg_mask_i;
                    pscr_n = cfg_pscr_i;
                    cnt_n  = cfg_cnt_i;
                    alrm_n = cfg_alrm_i;
                    err_n  = ERR_OK;
                    if (cfg_mask_i == 3'b000) begin
                        state_n = S_DONE;
                    end else if (cfg_mask_i[0] && (cfg_pscr_i < PSCR_LO)) begin
                        err_n   = ERR_PSCR;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_RD_CTRL;
                    end
                end
            end
            S_RD_CTRL: begin
                if (hs) begin
                    shadow_n = bus_rdata_i[4:0];
                    poll_n   = '0;
                    state_n  = S_POLL1;
                end
            end
            S_POLL1, S_POLL2: begin
                if (hs) begin
                    if (bus_rdata_i[1]) begin
                        state_n = (state_q == S_POLL1) ? S_WR_ENTER : S_DONE;
                    end else begin
                        poll_n = poll_inc;
                        if (poll_inc == POLL_LAST) begin
                            err_n   = ERR_TMO;
                            state_n = S_DONE;
                        end
                    end
                end
            end
            S_WR_ENTER: if (hs) state_n = next_write(mask_q);
            S_WR_PSCR:  if (hs) state_n = next_write(mask_q & 3'b110);
            S_WR_CNT:   if (hs) state_n = next_write(mask_q & 3'b100);
            S_WR_ALRM:  if (hs) state_n = S_WR_EXIT;
            S_WR_EXIT: begin
                if (hs) begin
                    poll_n  = '0;
                    state_n = S_POLL2;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            pscr_q   <= '0;
            cnt_q    <= '0;
            alrm_q   <= '0;
            shadow_q <= '0;
            poll_q   <= '0;
            err_q    <= ERR_OK;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_n;
            mask_q   <= mask_n;
            pscr_q   <= pscr_n;
            cnt_q    <= cnt_n;
            alrm_q   <= alrm_n;
            shadow_q <= shadow_n;
            poll_q   <= poll_n;
            err_q    <= err_n;
            req_q    <= req_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
        end
    end

    assign cfg_rdy_o   = (state_q == S_IDLE);
    assign cfg_done_o  = (state_q == S_DONE);
    assign cfg_err_o   = err_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;

endmodule
